// File: rtl/uop_queue_mp_if.sv
// uop_queue_mp_if: bundles the push, pop and status signals of uop_queue_mp.
//   slave  : the queue side (takes push lanes, get_size and flush; drives the
//            accept, out lanes and occupancy status).
//   master : the decode/issue side (drives push lanes, get_size and flush).
//   Push  : in_uop (IN_W lanes of DATA_W), in_size, in_accept
//   Pop   : out_uop (OUT_W lanes of DATA_W), out_size, get_size
//   Status: q_elements, q_space, almost_full, empty
//   Flush : flush
interface uop_queue_mp_if #(
   parameter int DATA_W = 64,
   parameter int IN_W   = 4,
   parameter int OUT_W  = 2,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ISZ_W = $clog2(IN_W + 1);
   localparam int OSZ_W = $clog2(OUT_W + 1);

   logic                    flush;
   logic [IN_W*DATA_W-1:0]  in_uop;
   logic [ISZ_W-1:0]        in_size;
   logic                    in_accept;
   logic [OUT_W*DATA_W-1:0] out_uop;
   logic [OSZ_W-1:0]        out_size;
   logic [OSZ_W-1:0]        get_size;
   logic [CNT_W-1:0]        q_elements;
   logic [CNT_W-1:0]        q_space;
   logic                    almost_full;
   logic                    empty;

   modport slave (
      input  flush, in_uop, in_size, get_size,
      output in_accept, out_uop, out_size, q_elements, q_space, almost_full, empty
   );

   modport master (
      output flush, in_uop, in_size, get_size,
      input  in_accept, out_uop, out_size, q_elements, q_space, almost_full, empty
   );
endinterface

// File: rtl/uop_queue_mp.sv
// uop_queue_mp: multi-port circular uop queue between decode and issue/rename.
// Accepts an all-or-nothing burst of up to IN_W uops per cycle and releases up
// to OUT_W uops per cycle; the consumer says how many it took via get_size.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset of head/tail/count
//   q     : uop_queue_mp_if.slave (push lanes, pop lanes, flush, status)
// Storage is not reset. out_uop/out_size are combinational from registered
// state only, so a pushed uop appears on the out lanes one cycle after write.
module uop_queue_mp #(
   parameter int DATA_W    = 64,
   parameter int IN_W      = 4,
   parameter int OUT_W     = 2,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12
) (
   input logic             clk,
   input logic             reset,
   uop_queue_mp_if.slave   q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ISZ_W = $clog2(IN_W + 1);
   localparam int OSZ_W = $clog2(OUT_W + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic [CNT_W-1:0]  space;
   logic [OSZ_W-1:0]  avail;
   logic [OSZ_W-1:0]  pop_n;
   logic              push_acc;
   logic [ISZ_W-1:0]  push_n;

   // Status and handshake, all derived from start-of-cycle state.
   always_comb begin
      space = CNT_W'(DEPTH) - count;

      avail = (count >= CNT_W'(OUT_W)) ? OSZ_W'(OUT_W) : OSZ_W'(count);

      // Oversized get_size is clipped, not flagged.
      pop_n = (q.get_size > avail) ? avail : q.get_size;

      // Space freed by a same-cycle pop is deliberately not counted; reset
      // holds the accept low so nothing is acknowledged while state is cleared.
      push_acc = reset && !q.flush && (q.in_size != '0) &&
                 (CNT_W'(q.in_size) <= space);
      push_n   = push_acc ? q.in_size : '0;

      q.in_accept   = push_acc;
      q.out_size    = avail;
      q.q_elements  = count;
      q.q_space     = space;
      q.almost_full = (count >= CNT_W'(AF_THRESH));
      q.empty       = (count == '0);

      // Out lanes wrap modulo DEPTH through natural pointer overflow.
      q.out_uop = '0;
      for (int i = 0; i < OUT_W; i++) begin
         q.out_uop[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)];
      end
   end

   // Pointer and occupancy registers; flush outranks push and pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (q.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= CNT_W'({1'b0, count} + (CNT_W+1)'(push_n) - (CNT_W+1)'(pop_n));
      end
   end

   // Entry storage; a burst may straddle index DEPTH-1 -> 0.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_W; i++) begin
         if (push_acc && (ISZ_W'(i) < q.in_size)) begin
            mem[tail + PTR_W'(i)] <= q.in_uop[i*DATA_W +: DATA_W];
         end
      end
   end
endmodule

// File: doc/uop_queue_mp.md
Name: uop_queue_mp

Overview:
Parametrised multi-port circular uop queue. It is the successor to the fixed-width decode uop queue and sits between decode and the issue/rename stage. Each cycle it accepts a variable-size burst of up to IN_W uops and releases a variable number of up to OUT_W uops. Compared with the earlier queue it adds:
- registered storage;
- explicit full/empty tracking through an occupancy counter;
- a partial-pop handshake;
- a flush;
- an almost-full threshold.

Parameters:
- DATA_W, 64: bits per uop entry.
- IN_W, 4: max uops pushed per cycle.
- OUT_W, 2: max uops popped per cycle.
- DEPTH, 16: entries. Must be a power of two and ≥ max(IN_W, OUT_W).
- AF_THRESH, 12: almost_full asserts when occupancy ≥ AF_THRESH.
- Derived:
  - PTR_W = clog2(DEPTH)
  - CNT_W = clog2(DEPTH+1)
  - ISZ_W = clog2(IN_W+1)
  - OSZ_W = clog2(OUT_W+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all contents.
- in_uop  in  IN_W*DATA_W  push lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- in_size  in  ISZ_W  number of valid push lanes (0..IN_W); lanes 0..in_size-1 are valid.
- in_accept  out  1  burst accepted this cycle.
- out_uop  out  OUT_W*DATA_W  entries head .. head+OUT_W-1 (modulo DEPTH).
- out_size  out  OSZ_W  number of valid out lanes = min(count, OUT_W).
- get_size  in  OSZ_W  number of uops the consumer takes this cycle.
- q_elements  out  CNT_W  current occupancy.
- q_space  out  CNT_W  DEPTH − q_elements.
- almost_full  out  1  q_elements ≥ AF_THRESH.
- empty  out  1  q_elements == 0.

Behaviour:
- State:
  - head and tail pointers (PTR_W each), wrapping naturally at DEPTH.
  - count register (CNT_W), the sole source of full/empty.
  - mem[DEPTH] of DATA_W bits.
- Reset, asynchronous (reset = 0):
  - head = tail = count = 0.
  - Outputs: in_accept = 0, out_size = 0, q_elements = 0, q_space = DEPTH, almost_full = 0, empty = 1.
  - mem contents are not reset; out_uop is don't-care while out_size = 0.
- Push rule:
  - in_accept = (in_size > 0) && (in_size ≤ q_space) && !flush. The check uses start-of-cycle q_space; space freed by a same-cycle pop is not counted.
  - A burst is all-or-nothing; there are no partial pushes.
  - in_size > IN_W is illegal; the bench asserts on it.
  - On accept: mem[tail+i] ← lane i for i < in_size; tail ← tail + in_size.
- Pop rule:
  - pop_n = min(get_size, out_size).
  - get_size larger than out_size is clipped silently, not treated as an error.
  - head ← head + pop_n.
  - out_uop and out_size are combinational from registered state, so data is visible in the same cycle it is popped.
  - A pushed uop is first visible on out_uop the cycle after it is written (latency 1).
- Count: count ← count + (in_accept ? in_size : 0) − pop_n, evaluated in one expression at CNT_W+1 bits. No overflow or underflow is reachable.
- Simultaneous push and pop: both take effect in the same cycle. If count is DEPTH−1, a 2-uop push is rejected even when a 2-uop pop occurs in that cycle (conservative rule).
- Flush:
  - Highest priority: head ← 0, tail ← 0, count ← 0.
  - Any push and pop in that cycle are ignored, and in_accept = 0.
- Wrap-around: pointer arithmetic is modulo DEPTH. A burst may straddle index DEPTH−1 → 0, and out lanes may straddle likewise.
- Reset asserted mid-burst: all state clears immediately. Sampled inputs are ignored until the first rising edge after reset deasserts.
- No combinational path from in_uop to out_uop.

Test Plan:
- Reset then idle: reset = 0 for 2 cycles, then release → empty = 1, q_space = 16, out_size = 0, in_accept = 0 with in_size = 0.
- Fill to full: push 4 uops/cycle (values 0..15) for 4 cycles with get_size = 0 → in_accept = 1 each cycle, q_elements = 16, almost_full = 1. A 5th push of 1 uop gives in_accept = 0 and no state change.
- Partial drain: from full, get_size = 2 for 3 cycles → out_uop shows pairs (0,1), (2,3), (4,5); q_elements = 10; almost_full deasserts when count reaches 10.
- Wrap and straddle: set head = tail = 14 (push 14, pop 14), then push 4 (A,B,C,D) → entries stored at indices 14, 15, 0, 1. Next cycle out_uop = (A,B); pop 2, then out_uop = (C,D).
- Simultaneous push/pop and edge cases:
  - count = 15, push 2 + pop 2 → push rejected, count = 13.
  - count = 1, get_size = 2 → pop_n = 1, count = 0, empty = 1.
- Flush priority: count = 8, flush = 1 with push 3 and get_size 2 in the same cycle → next cycle count = 0, head = tail = 0, in_accept was 0. Async reset pulse mid-fill → immediate empty = 1.
